mesh_term_inject: RTL



---
 rtl/mesh_inj_pkg.sv | 31 +++
 rtl/mesh_term_inject_if.sv | 12 +
 rtl/mesh_inj_fifo.sv | 53 +++++
 rtl/mesh_term_inject.sv | 92 +++++++++
 4 files changed

// File: rtl/mesh_inj_pkg.sv
// Shared packet layout and destination screening for the mesh terminal injector.
package mesh_inj_pkg;

  localparam int NXT_W = 8;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int HDR_W = 18;

  // Header occupies the top HDR_W bits; rsvd pads the bit just above the payload.
  typedef struct packed {
    logic [NXT_W-1:0] nxt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
    logic             rsvd;
  } hdr_t;

  // Legal destinations are the edge terminals ringing the ROWS x COLUMS mesh, excluding corners.
  function automatic logic dest_legal(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col,
                                      input int rows,
                                      input int cols);
    int r;
    int c;
    r = int'(row);
    c = int'(col);
    return (((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols)) ||
           (((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows));
  endfunction

endpackage

// File: rtl/mesh_term_inject_if.sv
// Host request channel into the mesh terminal injector (valid/ready handshake).
interface mesh_term_inject_if #(parameter int PAY_W = 22);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_row;
  logic [3:0]       in_col;
  logic             in_mode;
  logic [PAY_W-1:0] in_payload;

  modport master (output in_valid, in_row, in_col, in_mode, in_payload, input in_ready);
  modport slave  (input in_valid, in_row, in_col, in_mode, in_payload, output in_ready);
endinterface

// File: rtl/mesh_inj_fifo.sv
// Circular FIFO with occupancy counter; depth need not be a power of two.
module mesh_inj_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mesh_term_inject.sv
// Per-terminal injection stage: formats host requests into mesh packets, drops illegal
// destinations, and queues them for the router pop port. Optional stall watchdog: MESH_INJ_WATCHDOG_EN.
module mesh_term_inject
  import mesh_inj_pkg::*;
#(
  parameter int               ROWS       = 4,
  parameter int               COLUMS     = 4,
  parameter int               pckg_sz    = 40,
  parameter int               fifo_depth = 10,
  parameter logic [pckg_sz-19:0] bdcst   = {(pckg_sz-18){1'b1}},
  parameter int               WD_LIMIT   = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  mesh_term_inject_if.slave               host,
  output logic                            pndng,
  output logic [pckg_sz-1:0]              data_out,
  input  logic                            popin,
  output logic [$clog2(fifo_depth+1)-1:0] count,
  output logic [7:0]                      drop_cnt,
  output logic                            underflow,
  output logic                            stall_err
);

  localparam int CNT_W = $clog2(fifo_depth + 1);

  hdr_t               hdr;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] head;
  logic               accept;
  logic               legal;
  logic               push;
  logic               pop;

  assign hdr = '{nxt: '0, row: host.in_row, col: host.in_col, mode: host.in_mode, rsvd: 1'b0};
  assign pkt = {hdr, host.in_payload};

  // No full-bypass: a pop in the same cycle does not open the door.
  assign host.in_ready = (count < CNT_W'(fifo_depth));
  assign accept        = host.in_valid && host.in_ready;
  assign legal         = (host.in_payload == bdcst) ||
                         dest_legal(host.in_row, host.in_col, ROWS, COLUMS);
  assign push          = accept && legal;
  assign pndng         = (count != '0);
  assign pop           = popin && pndng;
  assign data_out      = pndng ? head : '0;

  mesh_inj_fifo #(
    .DATA_W (pckg_sz),
    .DEPTH  (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .wdata (pkt),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      if (accept && !legal && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (popin && !pndng) underflow <= 1'b1;
    end
  end

`ifdef MESH_INJ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Flag rises on the same edge the counter reaches WD_LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else begin
      if (!pndng || popin)                   wd_cnt <= '0;
      else if (wd_cnt != WD_W'(WD_LIMIT))    wd_cnt <= wd_cnt + WD_W'(1);
      if (pndng && !popin && (wd_cnt == WD_W'(WD_LIMIT - 1))) stall_err <= 1'b1;
    end
  end
`else
  // Constant 0 for any non-negative limit.
  assign stall_err = (WD_LIMIT < 0);
`endif

endmodule
